// File: rtl/mc_datapath_if.sv
// Bus between the multicycle controller / unified memory and the datapath.
// The controller-side (master) drives step controls and memory responses;
// the datapath (slave) returns address, store data, IR and status.
interface mc_datapath_if #(
  parameter int WIDTH = 32
);
  logic                        PCWrite;
  logic                        AdrSrc;
  logic                        IRWrite;
  logic                        RegWrite;
  logic [1:0]                  RegSrc;
  logic [1:0]                  ImmSrc;
  logic                        ALUSrcA;
  logic [1:0]                  ALUSrcB;
  logic [2:0]                  ALUControl;
  logic [1:0]                  ResultSrc;
  logic                        MemReq;
  logic                        mem_ready;
  logic [WIDTH-1:0]            Adr;
  logic [WIDTH-1:0]            WriteData;
  logic [WIDTH-1:0]            ReadData;
  logic [31:0]                 Instr;
  logic [3:0]                  ALUFlags;
  logic                        stall;
  logic [14:0][WIDTH-1:0]      registers;

  modport master (
    output PCWrite, AdrSrc, IRWrite, RegWrite, RegSrc, ImmSrc, ALUSrcA,
           ALUSrcB, ALUControl, ResultSrc, MemReq, mem_ready, ReadData,
    input  Adr, WriteData, Instr, ALUFlags, stall, registers
  );

  modport slave (
    input  PCWrite, AdrSrc, IRWrite, RegWrite, RegSrc, ImmSrc, ALUSrcA,
           ALUSrcB, ALUControl, ResultSrc, MemReq, mem_ready, ReadData,
    output Adr, WriteData, Instr, ALUFlags, stall, registers
  );
endinterface

// File: rtl/mc_datapath.sv
// Multicycle ARM datapath: one shared memory port, non-architectural
// IR/Data/A/WD/ALUOut registers, a single ALU, and a memory-stall freeze.
module mc_datapath #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          reset,
  mc_datapath_if.slave bus
);
  logic [WIDTH-1:0] pc, data, a, wd, aluout;
  logic [31:0]      ir;
  // Entry 15 is never written; reads of index 15 are redirected to PC+4.
  logic [WIDTH-1:0] rf [16];

  logic [3:0]       ra1, ra2, wa;
  logic [WIDTH-1:0] rd1, rd2, extimm, srca, srcb, beff, alures, result;
  logic [WIDTH:0]   sum;
  logic             sub, cflag, vflag, stall;

  assign stall     = bus.MemReq & ~bus.mem_ready;
  assign bus.stall = stall;

  assign ra1 = bus.RegSrc[0] ? 4'hF : ir[19:16];
  assign ra2 = bus.RegSrc[1] ? ir[15:12] : ir[3:0];
  assign wa  = ir[15:12];

  // PC already points past the fetched word, so PC+4 is the ARM r15 view.
  assign rd1 = (ra1 == 4'hF) ? pc + WIDTH'(4) : rf[ra1];
  assign rd2 = (ra2 == 4'hF) ? pc + WIDTH'(4) : rf[ra2];

  // Immediate extension from the IR fields.
  always_comb begin
    extimm = '0;
    case (bus.ImmSrc)
      2'b00:   extimm = {{(WIDTH-8){1'b0}}, ir[7:0]};
      2'b01:   extimm = {{(WIDTH-12){1'b0}}, ir[11:0]};
      2'b10:   extimm = {{(WIDTH-26){ir[23]}}, ir[23:0], 2'b00};
      default: extimm = '0;
    endcase
  end

  // ALU operand B select; the unused encoding feeds zero.
  always_comb begin
    srcb = '0;
    case (bus.ALUSrcB)
      2'b00:   srcb = wd;
      2'b01:   srcb = extimm;
      2'b10:   srcb = WIDTH'(4);
      default: srcb = '0;
    endcase
  end

  assign srca = bus.ALUSrcA ? pc : a;

  // Shared adder: SUB is A + ~B + 1 so carry means "no borrow".
  assign sub  = (bus.ALUControl == 3'b001);
  assign beff = sub ? ~srcb : srcb;
  assign sum  = {1'b0, srca} + {1'b0, beff} + {{WIDTH{1'b0}}, sub};

  // ALU result and arithmetic flags; logic ops clear C and V.
  always_comb begin
    alures = '0;
    cflag  = 1'b0;
    vflag  = 1'b0;
    case (bus.ALUControl)
      3'b000, 3'b001: begin
        alures = sum[WIDTH-1:0];
        cflag  = sum[WIDTH];
        vflag  = (srca[WIDTH-1] == beff[WIDTH-1]) && (sum[WIDTH-1] != srca[WIDTH-1]);
      end
      3'b010:  alures = srca & srcb;
      3'b011:  alures = srca | srcb;
      3'b100:  alures = srca ^ srcb;
      default: alures = '0;
    endcase
  end

  assign bus.ALUFlags = {alures[WIDTH-1], (alures == '0), cflag, vflag};

  // Result mux; encoding 11 aliases ALUOut.
  always_comb begin
    result = aluout;
    case (bus.ResultSrc)
      2'b01:   result = data;
      2'b10:   result = alures;
      default: result = aluout;
    endcase
  end

  assign bus.Adr       = bus.AdrSrc ? result : pc;
  assign bus.WriteData = wd;
  assign bus.Instr     = ir;

  // Debug view of r0..r14.
  for (genvar i = 0; i < 15; i++) begin : g_regs
    assign bus.registers[i] = rf[i];
  end

  // All architectural and step state; reset wins, a stall freezes everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      ir     <= '0;
      data   <= '0;
      a      <= '0;
      wd     <= '0;
      aluout <= '0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (!stall) begin
      if (bus.PCWrite) pc <= result;
      if (bus.IRWrite) ir <= bus.ReadData[31:0];
      data   <= bus.ReadData;
      a      <= rd1;
      wd     <= rd2;
      aluout <= alures;
      // r15 writes are dropped: the PC only moves through PCWrite.
      if (bus.RegWrite && (wa != 4'hF)) rf[wa] <= result;
    end
  end
endmodule

// File: tb/tb_mc_datapath.sv
// Scoreboarded bench for mc_datapath: directed controller step sequences
// followed by random control/memory traffic against an arithmetic model.
module tb_mc_datapath;
  localparam int          W   = 32;
  localparam logic [31:0] RPC = 32'h100;
  localparam longint      MAXS = 64'sd2147483647;
  localparam longint      MINS = -64'sd2147483648;
  localparam longint      TWO32 = 64'sd4294967296;

  logic clk = 1'b0;
  logic reset;

  mc_datapath_if #(.WIDTH(W)) bus();
  mc_datapath #(.WIDTH(W), .RESET_PC(RPC)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    bit        rst, pcw, adrsrc, irw, regw;
    bit [1:0]  regsrc, immsrc;
    bit        srca;
    bit [1:0]  srcb;
    bit [2:0]  aluc;
    bit [1:0]  ressrc;
    bit        memreq, memrdy;
    bit [31:0] rdata;
  } ctrl_t;

  typedef struct packed {
    bit [31:0]       adr, wdata, instr;
    bit [3:0]        flags;
    bit              stall;
    bit [14:0][31:0] regs;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference state of the machine (architectural + step registers).
  bit [31:0] m_pc, m_ir, m_data, m_a, m_wd, m_aluout;
  bit [31:0] m_rf [15];
  bit        m_known = 1'b0;

  function automatic bit [31:0] rdreg(input bit [3:0] i);
    return (i == 4'd15) ? m_pc + 32'd4 : m_rf[i];
  endfunction

  // Arithmetic reference: carry/overflow from wide signed/unsigned math.
  function automatic void alu(input bit [2:0] op, input bit [31:0] x, y,
                              output bit [31:0] r, output bit [3:0] f);
    longint t;
    bit c, v;
    c = 1'b0; v = 1'b0; r = '0;
    case (op)
      3'd0: begin
        r = x + y;
        c = (longint'(x) + longint'(y)) >= TWO32;
        t = longint'($signed(x)) + longint'($signed(y));
        v = (t > MAXS) || (t < MINS);
      end
      3'd1: begin
        r = x - y;
        c = (x >= y);
        t = longint'($signed(x)) - longint'($signed(y));
        v = (t > MAXS) || (t < MINS);
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      default: r = '0;
    endcase
    f = {r[31], (r == 32'd0), c, v};
  endfunction

  // Drive one controller step; push expected outputs; advance the model.
  task automatic step(input ctrl_t c);
    bit [3:0]  ra1, ra2, wa, f;
    bit [31:0] rd1, rd2, ext, sa, sb, r, res;
    bit        stl;
    exp_t      e;
    @(negedge clk);
    reset          = c.rst;
    bus.PCWrite    = c.pcw;    bus.AdrSrc    = c.adrsrc;
    bus.IRWrite    = c.irw;    bus.RegWrite  = c.regw;
    bus.RegSrc     = c.regsrc; bus.ImmSrc    = c.immsrc;
    bus.ALUSrcA    = c.srca;   bus.ALUSrcB   = c.srcb;
    bus.ALUControl = c.aluc;   bus.ResultSrc = c.ressrc;
    bus.MemReq     = c.memreq; bus.mem_ready = c.memrdy;
    bus.ReadData   = c.rdata;

    ra1 = c.regsrc[0] ? 4'd15 : m_ir[19:16];
    ra2 = c.regsrc[1] ? m_ir[15:12] : m_ir[3:0];
    rd1 = rdreg(ra1);
    rd2 = rdreg(ra2);
    case (c.immsrc)
      2'd0:    ext = m_ir & 32'hFF;
      2'd1:    ext = m_ir & 32'hFFF;
      2'd2:    ext = 32'(int'(m_ir << 8) >>> 6);
      default: ext = 32'd0;
    endcase
    sa = c.srca ? m_pc : m_a;
    case (c.srcb)
      2'd0:    sb = m_wd;
      2'd1:    sb = ext;
      2'd2:    sb = 32'd4;
      default: sb = 32'd0;
    endcase
    alu(c.aluc, sa, sb, r, f);
    case (c.ressrc)
      2'd1:    res = m_data;
      2'd2:    res = r;
      default: res = m_aluout;
    endcase
    stl = c.memreq && !c.memrdy;

    if (m_known) begin
      e.adr   = c.adrsrc ? res : m_pc;
      e.wdata = m_wd;
      e.instr = m_ir;
      e.flags = f;
      e.stall = stl;
      for (int i = 0; i < 15; i++) e.regs[i] = m_rf[i];
      q.push_back(e);
    end

    if (c.rst) begin
      m_pc = RPC; m_ir = '0; m_data = '0; m_a = '0; m_wd = '0; m_aluout = '0;
      for (int i = 0; i < 15; i++) m_rf[i] = '0;
      m_known = 1'b1;
    end else if (m_known && !stl) begin
      wa = m_ir[15:12];
      if (c.regw && wa != 4'd15) m_rf[wa] = res;
      if (c.pcw) m_pc = res;
      if (c.irw) m_ir = c.rdata;
      m_data   = c.rdata;
      m_a      = rd1;
      m_wd     = rd2;
      m_aluout = r;
    end
  endtask

  function automatic ctrl_t idle();
    ctrl_t c;
    c = '0;
    return c;
  endfunction

  // Fetch with an optional number of wait cycles before mem_ready.
  task automatic fetch(input bit [31:0] instr, input int nwait);
    ctrl_t c;
    c = idle();
    c.irw = 1'b1; c.srca = 1'b1; c.srcb = 2'd2; c.ressrc = 2'd2;
    c.pcw = 1'b1; c.memreq = 1'b1; c.rdata = instr;
    for (int k = 0; k < nwait; k++) begin
      c.memrdy = 1'b0;
      step(c);
    end
    c.memrdy = 1'b1;
    step(c);
  endtask

  task automatic decode(input bit [1:0] regsrc);
    ctrl_t c;
    c = idle();
    c.regsrc = regsrc;
    step(c);
  endtask

  // LDR-style path: fetch, memory read into Data, write Data to Rd.
  task automatic loadreg(input bit [31:0] instr, input bit [31:0] val);
    ctrl_t c;
    fetch(instr, 0);
    c = idle();
    c.adrsrc = 1'b1; c.memreq = 1'b1; c.memrdy = 1'b1; c.rdata = val;
    step(c);
    c = idle();
    c.adrsrc = 1'b1; c.ressrc = 2'd1; c.regw = 1'b1;
    step(c);
  endtask

  // Execute with A as operand A, then write ALUOut back to Rd.
  task automatic exec_wb(input bit [2:0] aluc, input bit [1:0] srcb, input bit [1:0] immsrc);
    ctrl_t c;
    c = idle();
    c.aluc = aluc; c.srcb = srcb; c.immsrc = immsrc;
    step(c);
    c = idle();
    c.ressrc = 2'd0; c.regw = 1'b1;
    step(c);
  endtask

  function automatic ctrl_t rand_ctrl();
    ctrl_t c;
    c.rst    = ($urandom_range(0, 63) == 0);
    c.pcw    = 1'($urandom_range(0, 1));
    c.adrsrc = 1'($urandom_range(0, 1));
    c.irw    = 1'($urandom_range(0, 1));
    c.regw   = 1'($urandom_range(0, 1));
    c.regsrc = 2'($urandom_range(0, 3));
    c.immsrc = 2'($urandom_range(0, 3));
    c.srca   = 1'($urandom_range(0, 1));
    c.srcb   = 2'($urandom_range(0, 2));
    c.aluc   = 3'($urandom_range(0, 7));
    c.ressrc = 2'($urandom_range(0, 3));
    c.memreq = 1'($urandom_range(0, 1));
    c.memrdy = ($urandom_range(0, 3) != 0);
    c.rdata  = $urandom;
    return c;
  endfunction

  task automatic cmp(input string nm, input logic [479:0] act, input logic [479:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Monitor: every cycle with a pending expectation, compare the settled outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        cmp("adr",   480'(bus.Adr),       480'(e.adr));
        cmp("wdata", 480'(bus.WriteData), 480'(e.wdata));
        cmp("instr", 480'(bus.Instr),     480'(e.instr));
        cmp("flags", 480'(bus.ALUFlags),  480'(e.flags));
        cmp("stall", 480'(bus.stall),     480'(e.stall));
        cmp("regs",  480'(bus.registers), 480'(e.regs));
      end
    end
  end

  initial begin
    ctrl_t c;
    reset = 1'b1;
    bus.PCWrite = 0; bus.AdrSrc = 0; bus.IRWrite = 0; bus.RegWrite = 0;
    bus.RegSrc = 0; bus.ImmSrc = 0; bus.ALUSrcA = 0; bus.ALUSrcB = 0;
    bus.ALUControl = 0; bus.ResultSrc = 0; bus.MemReq = 1; bus.mem_ready = 0;
    bus.ReadData = 0;

    // Initial reset, some traffic, then reset again while stalled.
    c = idle(); c.rst = 1'b1; step(c);
    for (int k = 0; k < 6; k++) begin
      c = rand_ctrl(); c.rst = 1'b0; step(c);
    end
    c = idle(); c.rst = 1'b1; c.memreq = 1'b1; c.memrdy = 1'b0; step(c);

    fetch(32'hE281_1005, 0);                 // IR loads, PC -> 0x104
    fetch(32'hE3A0_0000, 3);                 // three stalled edges first
    loadreg(32'hE590_1000, 32'd7);           // r1 = 7
    fetch(32'hE281_1005, 0); decode(2'b00);  // ADD r1, r1, #5
    exec_wb(3'd0, 2'd1, 2'd0);
    loadreg(32'hE590_2000, 32'd5);           // r2 = 5
    fetch(32'hE042_2002, 0); decode(2'b00);  // SUB r2, r2, r2 -> Z, C
    exec_wb(3'd1, 2'd0, 2'd0);
    loadreg(32'hE590_3000, 32'h7FFF_FFFF);   // r3 = max positive
    fetch(32'hE283_3001, 0); decode(2'b00);  // ADD r3, r3, #1 -> N, V
    exec_wb(3'd0, 2'd1, 2'd0);

    // r15 read lands in A as PC+4; expose A on Adr, then try to write r15.
    fetch(32'hE28F_F000, 0); decode(2'b01);
    c = idle(); c.srcb = 2'd1; c.immsrc = 2'd3; c.adrsrc = 1'b1; c.ressrc = 2'd2;
    step(c);
    c = idle(); c.regw = 1'b1; c.ressrc = 2'd2; c.srca = 1'b1; c.srcb = 2'd2;
    step(c);

    loadreg(32'hE590_4000, 32'hDEAD_BEEF);   // LDR path into r4
    c = idle(); step(c);

    for (int k = 0; k < 1500; k++) begin
      c = rand_ctrl();
      step(c);
    end
    c = idle(); step(c);

    for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mc_datapath.md
Name: mc_datapath

Overview:
Multicycle ARM datapath, successor to the single-cycle datapath. Uses one unified memory port for both instructions and data, and holds intermediate values in non-architectural registers (IR, Data, A, WD, ALUOut) so that one ALU serves all steps. Adds a memory handshake that stalls every state update, a synchronous register-file clear, and width/reset-vector parameters. It is driven step-by-step by an external multicycle controller FSM.

Parameters:
WIDTH, 32, data/address path width; must be >= 32; instruction is always ReadData[31:0].
RESET_PC, 0, value loaded into PC on reset.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high
PCWrite  in  1  PC load enable
AdrSrc  in  1  memory address select: 0 = PC, 1 = Result
IRWrite  in  1  instruction register load enable
RegWrite  in  1  register file write enable
RegSrc  in  2  [0] RA1 = 15; [1] RA2 = Instr[15:12]
ImmSrc  in  2  immediate format
ALUSrcA  in  1  0 = A, 1 = PC
ALUSrcB  in  2  00 = WD, 01 = ExtImm, 10 = 4
ALUControl  in  3  ALU operation
ResultSrc  in  2  00 = ALUOut, 01 = Data, 10 = ALUResult
MemReq  in  1  controller requests a memory access this cycle
mem_ready  in  1  memory completes the access this cycle
Adr  out  WIDTH  memory address
WriteData  out  WIDTH  store data (the WD register)
ReadData  in  WIDTH  memory read data
Instr  out  32  IR contents, for the controller
ALUFlags  out  4  {N,Z,C,V} of the current ALU operation
stall  out  1  MemReq & ~mem_ready
registers  out  15xWIDTH  debug view of r0..r14

Behaviour:
- stall = MemReq & ~mem_ready (combinational). While stall = 1, no state element changes: PC, IR, Data, A, WD, ALUOut and the register file are all held.
- Reset (synchronous, has priority over everything, including mid-stall): PC <= RESET_PC; IR, Data, A, WD, ALUOut <= 0; r0..r14 <= 0. After reset: Adr = RESET_PC, stall follows its inputs.
- When not stalled, each rising edge:
  - PC <= Result if PCWrite.
  - IR <= ReadData[31:0] if IRWrite.
  - Data, A, WD, ALUOut are loaded unconditionally with ReadData, RD1, RD2 and ALUResult respectively.
- Adr = AdrSrc ? Result : PC (combinational).
- Result mux is selected by ResultSrc; encoding 11 yields ALUOut.
- Register file:
  - RA1 = RegSrc[0] ? 15 : Instr[19:16]; RA2 = RegSrc[1] ? Instr[15:12] : Instr[3:0].
  - Reads are combinational. A read of index 15 returns PC + 4; PC already holds the fetch address + 4, so this equals the instruction address + 8.
  - Write: if RegWrite, Result is written to Instr[15:12]. A write to index 15 is discarded; the PC changes only via PCWrite.
- Extend:
  - ImmSrc 00: zero-extend Instr[7:0].
  - ImmSrc 01: zero-extend Instr[11:0].
  - ImmSrc 10: sign-extend {Instr[23:0], 2'b00}.
  - ImmSrc 11: 0.
- ALU, WIDTH bits wide:
  - ALUControl 000 = ADD, 001 = SUB (A + ~B + 1), 010 = AND, 011 = ORR, 100 = EOR; others yield 0.
  - N = MSB of result; Z = (result == 0).
  - C = carry out for ADD/SUB, 0 for logic ops.
  - V = signed overflow for ADD/SUB, 0 for logic ops.
- Latency: a register-file read reaches A/WD one edge later. ALUOut holds the previous cycle's ALU result. Data holds the previous cycle's ReadData.
- Simultaneous events: with PCWrite, IRWrite and RegWrite all asserted in the same cycle, every update uses pre-edge values. MemReq with mem_ready = 1 in the same cycle means no stall.

Test Plan:
- Reset with RESET_PC = 0x100: assert reset during a stall → next edge PC = 0x100, IR = 0, r0..r14 = 0, Adr = 0x100.
- Fetch step (AdrSrc=0, IRWrite, ALUSrcA=1, ALUSrcB=10, ALUControl=000, ResultSrc=10, PCWrite, MemReq=1, mem_ready=1), ReadData = 0xE2811005 → IR = 0xE2811005, PC = 0x104.
- Repeat the fetch with mem_ready low for 3 cycles → stall = 1; PC, IR and ALUOut unchanged for 3 edges; updates occur on the 4th edge.
- ADD r1, r1, #5 with r1 = 7: decode, then execute (ALUSrcB=01, ImmSrc=00), then writeback (ResultSrc=00, RegWrite) → r1 = 12, flags 0000.
- R15 read: PC = 0x104, RegSrc[0] = 1 → A = 0x108 next edge. RegWrite to Instr[15:12] = 15 → r0..r14 and PC unchanged.
- Flag corners: SUB 5 − 5 → Z=1, C=1. ADD 0x7FFFFFFF + 1 → N=1, V=1. LDR path: AdrSrc=1, ResultSrc=01, ReadData = 0xDEADBEEF → destination register = 0xDEADBEEF.
